// File: rtl/position_update_function_if.sv
// Sprite position bus between the movement/AI logic (master) and the
// position update block (slave).
interface position_update_function_if;
  logic [10:0] curr_pos_x;
  logic [9:0]  curr_pos_y;
  logic [3:0]  move_direction;
  logic [2:0]  which_sprite;
  logic [10:0] new_pos_x;
  logic [9:0]  new_pos_y;

  modport master (
    output curr_pos_x, curr_pos_y, move_direction, which_sprite,
    input  new_pos_x, new_pos_y
  );

  modport slave (
    input  curr_pos_x, curr_pos_y, move_direction, which_sprite,
    output new_pos_x, new_pos_y
  );
endinterface

// File: rtl/position_update_function.sv
// Steps a sprite one maze tile in a one-hot direction and returns the tile-centre pixel.
// Macro POS_WRAP_EN: defined = wrap at grid edges, undefined = off-grid steps are suppressed.
module position_update_function #(
  parameter int X_ORG      = 336,
  parameter int Y_ORG      = 27,
  parameter int TILE_SHIFT = 4,
  parameter int CENTER_OFF = 7,
  parameter int COLS       = 80,
  parameter int ROWS       = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  position_update_function_if.slave  bus
);

  localparam int TXW = $clog2(COLS);
  localparam int TYW = $clog2(ROWS);

  localparam logic [10:0]    X_ORG_L  = 11'(X_ORG);
  localparam logic [9:0]     Y_ORG_L  = 10'(Y_ORG);
  localparam logic [10:0]    TX_LIMIT = 11'(COLS - 1);
  localparam logic [9:0]     TY_LIMIT = 10'(ROWS - 1);
  localparam logic [TXW-1:0] TX_MAX   = TXW'(COLS - 1);
  localparam logic [TYW-1:0] TY_MAX   = TYW'(ROWS - 1);
  localparam logic [TXW-1:0] TX_ONE   = TXW'(1);
  localparam logic [TYW-1:0] TY_ONE   = TYW'(1);

  // Tile a step lands on when it would leave the grid.
`ifdef POS_WRAP_EN
  localparam logic [TXW-1:0] TX_PAST_LEFT  = TX_MAX;
  localparam logic [TXW-1:0] TX_PAST_RIGHT = TXW'(0);
  localparam logic [TYW-1:0] TY_PAST_TOP   = TY_MAX;
  localparam logic [TYW-1:0] TY_PAST_BOT   = TYW'(0);
`else
  localparam logic [TXW-1:0] TX_PAST_LEFT  = TXW'(0);
  localparam logic [TXW-1:0] TX_PAST_RIGHT = TX_MAX;
  localparam logic [TYW-1:0] TY_PAST_TOP   = TYW'(0);
  localparam logic [TYW-1:0] TY_PAST_BOT   = TY_MAX;
`endif

  localparam logic [10:0] HX_PACMAN = 11'(X_ORG + CENTER_OFF + (64 << TILE_SHIFT));
  localparam logic [10:0] HX_BLINKY = 11'(X_ORG + CENTER_OFF + (40 << TILE_SHIFT));
  localparam logic [10:0] HX_PINKY  = 11'(X_ORG + CENTER_OFF + (40 << TILE_SHIFT));
  localparam logic [10:0] HX_INKY   = 11'(X_ORG + CENTER_OFF + (38 << TILE_SHIFT));
  localparam logic [10:0] HX_CLYDE  = 11'(X_ORG + CENTER_OFF + (42 << TILE_SHIFT));
  localparam logic [9:0]  HY_ROW14  = 10'(Y_ORG + CENTER_OFF + (14 << TILE_SHIFT));
  localparam logic [9:0]  HY_ROW17  = 10'(Y_ORG + CENTER_OFF + (17 << TILE_SHIFT));

  // Modular 11/10-bit sums equal the full-width result truncated.
  function automatic logic [10:0] tile_to_px_x(input logic [TXW-1:0] t);
    return 11'(X_ORG + CENTER_OFF) + (11'(t) << TILE_SHIFT);
  endfunction

  function automatic logic [9:0] tile_to_px_y(input logic [TYW-1:0] t);
    return 10'(Y_ORG + CENTER_OFF) + (10'(t) << TILE_SHIFT);
  endfunction

  logic [10:0]    dx_s;
  logic [9:0]     dy_s;
  logic [10:0]    tx_raw_s;
  logic [9:0]     ty_raw_s;
  logic [TXW-1:0] tx_s;
  logic [TYW-1:0] ty_s;
  logic [TXW-1:0] tx_next_s;
  logic [TYW-1:0] ty_next_s;
  logic [10:0]    new_pos_x_d;
  logic [9:0]     new_pos_y_d;
  logic [10:0]    new_pos_x_q;
  logic [9:0]     new_pos_y_q;
  logic [10:0]    home_x_s;
  logic [9:0]     home_y_s;

  // Pixel to tile: positions left/above the maze pin to 0, far positions clamp.
  always_comb begin
    dx_s     = (bus.curr_pos_x < X_ORG_L) ? 11'd0 : (bus.curr_pos_x - X_ORG_L);
    dy_s     = (bus.curr_pos_y < Y_ORG_L) ? 10'd0 : (bus.curr_pos_y - Y_ORG_L);
    tx_raw_s = dx_s >> TILE_SHIFT;
    ty_raw_s = dy_s >> TILE_SHIFT;
    tx_s     = (tx_raw_s > TX_LIMIT) ? TX_MAX : tx_raw_s[TXW-1:0];
    ty_s     = (ty_raw_s > TY_LIMIT) ? TY_MAX : ty_raw_s[TYW-1:0];
  end

  // One-tile step; anything not one-hot leaves the tile unchanged (snap to centre).
  always_comb begin
    tx_next_s = tx_s;
    ty_next_s = ty_s;
    case (bus.move_direction)
      4'b1000: tx_next_s = (tx_s == TXW'(0)) ? TX_PAST_LEFT  : (tx_s - TX_ONE);
      4'b0001: tx_next_s = (tx_s == TX_MAX)  ? TX_PAST_RIGHT : (tx_s + TX_ONE);
      4'b0010: ty_next_s = (ty_s == TYW'(0)) ? TY_PAST_TOP   : (ty_s - TY_ONE);
      4'b0100: ty_next_s = (ty_s == TY_MAX)  ? TY_PAST_BOT   : (ty_s + TY_ONE);
      default: begin
        tx_next_s = tx_s;
        ty_next_s = ty_s;
      end
    endcase
    new_pos_x_d = tile_to_px_x(tx_next_s);
    new_pos_y_d = tile_to_px_y(ty_next_s);
  end

  // Home position of the selected sprite; unknown codes fall back to pacman.
  always_comb begin
    home_x_s = HX_PACMAN;
    home_y_s = HY_ROW17;
    case (bus.which_sprite)
      3'd1: begin
        home_x_s = HX_BLINKY;
        home_y_s = HY_ROW14;
      end
      3'd2: home_x_s = HX_PINKY;
      3'd3: home_x_s = HX_INKY;
      3'd4: home_x_s = HX_CLYDE;
      default: begin
        home_x_s = HX_PACMAN;
        home_y_s = HY_ROW17;
      end
    endcase
  end

  // Output register, cleared to the pacman home.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_pos_x_q <= HX_PACMAN;
      new_pos_y_q <= HY_ROW17;
    end else begin
      new_pos_x_q <= new_pos_x_d;
      new_pos_y_q <= new_pos_y_d;
    end
  end

  // Reset overrides the outputs without waiting for a clock.
  assign bus.new_pos_x = rst ? home_x_s : new_pos_x_q;
  assign bus.new_pos_y = rst ? home_y_s : new_pos_y_q;

endmodule

// File: tb/tb_position_update_function.sv
// Directed-vector bench for position_update_function; wrap expectations follow POS_WRAP_EN.
module tb_position_update_function;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  position_update_function_if bus_if();

  position_update_function dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic drive(input logic [10:0] x, input logic [9:0] y, input logic [3:0] d);
    @(negedge clk);
    bus_if.curr_pos_x     = x;
    bus_if.curr_pos_y     = y;
    bus_if.move_direction = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [2:0]  sp [5] = '{3'd1, 3'd4, 3'd6, 3'd2, 3'd3};
    logic [10:0] ex [5] = '{11'd983, 11'd1015, 11'd1367, 11'd983, 11'd951};
    logic [9:0]  ey [5] = '{10'd258, 10'd306, 10'd306, 10'd306, 10'd306};
    rst                   = 1'b1;
    bus_if.which_sprite   = 3'd0;
    bus_if.curr_pos_x     = 11'd455;
    bus_if.curr_pos_y     = 10'd146;
    bus_if.move_direction = 4'b1000;
    #1;
    total_cnt++;
    if (bus_if.new_pos_x !== 11'd1367 || bus_if.new_pos_y !== 10'd306)
      $display("FAIL reset_pacman got (%0d,%0d) want (1367,306)", bus_if.new_pos_x, bus_if.new_pos_y);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      bus_if.which_sprite = sp[i];
      #1;
      total_cnt++;
      if (bus_if.new_pos_x !== ex[i] || bus_if.new_pos_y !== ey[i])
        $display("FAIL reset_home_%0d got (%0d,%0d) want (%0d,%0d)", sp[i],
                 bus_if.new_pos_x, bus_if.new_pos_y, ex[i], ey[i]);
      else pass_cnt++;
    end
    bus_if.which_sprite = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus_if.new_pos_x !== 11'd1367 || bus_if.new_pos_y !== 10'd306)
      $display("FAIL reset_reg_value got (%0d,%0d) want (1367,306)", bus_if.new_pos_x, bus_if.new_pos_y);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus_if.new_pos_x !== 11'd439 || bus_if.new_pos_y !== 10'd146)
      $display("FAIL reset_release_load got (%0d,%0d) want (439,146)", bus_if.new_pos_x, bus_if.new_pos_y);
    else pass_cnt++;
  endtask

  task automatic test_steps;
    logic [10:0] vx [8] = '{11'd455, 11'd359, 11'd460, 11'd460, 11'd100, 11'd2047, 11'd455, 11'd455};
    logic [9:0]  vy [8] = '{10'd146, 10'd434, 10'd150, 10'd150, 10'd10,  10'd1023, 10'd146, 10'd146};
    logic [3:0]  vd [8] = '{4'b1000, 4'b0100, 4'b0000, 4'b1010, 4'b0001, 4'b0000, 4'b0010, 4'b0001};
    logic [10:0] ex [8] = '{11'd439, 11'd359, 11'd455, 11'd455, 11'd359, 11'd1607, 11'd455, 11'd471};
    logic [9:0]  ey [8] = '{10'd146, 10'd450, 10'd146, 10'd146, 10'd34,  10'd594,  10'd130, 10'd146};
    for (int i = 0; i < 8; i++) begin
      drive(vx[i], vy[i], vd[i]);
      tick();
      total_cnt++;
      if (bus_if.new_pos_x !== ex[i] || bus_if.new_pos_y !== ey[i])
        $display("FAIL step_%0d in (%0d,%0d,%b) got (%0d,%0d) want (%0d,%0d)", i, vx[i], vy[i], vd[i],
                 bus_if.new_pos_x, bus_if.new_pos_y, ex[i], ey[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap;
    logic [10:0] vx [4] = '{11'd1607, 11'd343, 11'd343, 11'd343};
    logic [9:0]  vy [4] = '{10'd443,  10'd34,  10'd34,  10'd594};
    logic [3:0]  vd [4] = '{4'b0001,  4'b0010, 4'b1000, 4'b0100};
`ifdef POS_WRAP_EN
    logic [10:0] ex [4] = '{11'd343,  11'd343, 11'd1607, 11'd343};
    logic [9:0]  ey [4] = '{10'd450,  10'd594, 10'd34,   10'd34};
`else
    logic [10:0] ex [4] = '{11'd1607, 11'd343, 11'd343, 11'd343};
    logic [9:0]  ey [4] = '{10'd450,  10'd34,  10'd34,  10'd594};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(vx[i], vy[i], vd[i]);
      tick();
      total_cnt++;
      if (bus_if.new_pos_x !== ex[i] || bus_if.new_pos_y !== ey[i])
        $display("FAIL edge_%0d in (%0d,%0d,%b) got (%0d,%0d) want (%0d,%0d)", i, vx[i], vy[i], vd[i],
                 bus_if.new_pos_x, bus_if.new_pos_y, ex[i], ey[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] vx [3] = '{11'd359, 11'd455, 11'd460};
    logic [9:0]  vy [3] = '{10'd434, 10'd146, 10'd150};
    logic [3:0]  vd [3] = '{4'b0100, 4'b1000, 4'b0000};
    logic [10:0] ex [3] = '{11'd359, 11'd439, 11'd455};
    logic [9:0]  ey [3] = '{10'd450, 10'd146, 10'd146};
    logic [10:0] prev_x = 11'd471;
    logic [9:0]  prev_y = 10'd146;
    drive(11'd455, 10'd146, 4'b0001);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(vx[i], vy[i], vd[i]);
      #1;
      total_cnt++;
      if (bus_if.new_pos_x !== prev_x || bus_if.new_pos_y !== prev_y)
        $display("FAIL b2b_hold_%0d got (%0d,%0d) want (%0d,%0d)", i,
                 bus_if.new_pos_x, bus_if.new_pos_y, prev_x, prev_y);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus_if.new_pos_x !== ex[i] || bus_if.new_pos_y !== ey[i])
        $display("FAIL b2b_load_%0d got (%0d,%0d) want (%0d,%0d)", i,
                 bus_if.new_pos_x, bus_if.new_pos_y, ex[i], ey[i]);
      else pass_cnt++;
      prev_x = ex[i];
      prev_y = ey[i];
    end
  endtask

  task automatic test_reset_midmove;
    bus_if.which_sprite = 3'd2;
    drive(11'd455, 10'd146, 4'b1000);
    tick();
    total_cnt++;
    if (bus_if.new_pos_x !== 11'd439 || bus_if.new_pos_y !== 10'd146)
      $display("FAIL midmove_pre got (%0d,%0d) want (439,146)", bus_if.new_pos_x, bus_if.new_pos_y);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus_if.new_pos_x !== 11'd983 || bus_if.new_pos_y !== 10'd306)
      $display("FAIL midmove_assert got (%0d,%0d) want (983,306)", bus_if.new_pos_x, bus_if.new_pos_y);
    else pass_cnt++;
    bus_if.which_sprite = 3'd3;
    #1;
    total_cnt++;
    if (bus_if.new_pos_x !== 11'd951 || bus_if.new_pos_y !== 10'd306)
      $display("FAIL midmove_inky got (%0d,%0d) want (951,306)", bus_if.new_pos_x, bus_if.new_pos_y);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bus_if.curr_pos_x     = 11'd359;
    bus_if.curr_pos_y     = 10'd434;
    bus_if.move_direction = 4'b0100;
    #1;
    total_cnt++;
    if (bus_if.new_pos_x !== 11'd1367 || bus_if.new_pos_y !== 10'd306)
      $display("FAIL midmove_cleared got (%0d,%0d) want (1367,306)", bus_if.new_pos_x, bus_if.new_pos_y);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus_if.new_pos_x !== 11'd359 || bus_if.new_pos_y !== 10'd450)
      $display("FAIL midmove_release got (%0d,%0d) want (359,450)", bus_if.new_pos_x, bus_if.new_pos_y);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_steps();
    test_wrap();
    test_back_to_back();
    test_reset_midmove();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/position_update_function.md
Name: position_update_function

Overview:
- Computes the next on-screen pixel position of a maze sprite (pacman or one of four ghosts) from its current pixel position and a one-hot move direction.
- Converts pixel position to a maze tile, steps one tile, wraps at the edges, and converts back to the tile-centre pixel.
- Sits between the movement/AI logic, which supplies only legal directions, and the sprite renderer. Output is registered.

Parameters:
- X_ORG, 336, pixel x of the left edge of the maze area
- Y_ORG, 27, pixel y of the top edge of the maze area
- TILE_SHIFT, 4, log2 of the tile size (16 px tiles)
- CENTER_OFF, 7, pixel offset from tile corner to tile centre
- COLS, 80, maze width in tiles (columns 0..79)
- ROWS, 36, maze height in tiles (rows 0..35)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- curr_pos_x  in  11  current sprite centre, pixel x
- curr_pos_y  in  10  current sprite centre, pixel y
- move_direction  in  4  one-hot direction: [3]=left, [2]=down, [1]=up, [0]=right
- which_sprite  in  3  0=pacman, 1=blinky, 2=pinky, 3=inky, 4=clyde, 5..7 treated as pacman
- new_pos_x  out  11  next sprite centre, pixel x
- new_pos_y  out  10  next sprite centre, pixel y

Behaviour:
- Tile extraction:
  - tx = (curr_pos_x - X_ORG) >> TILE_SHIFT; ty = (curr_pos_y - Y_ORG) >> TILE_SHIFT.
  - If curr_pos_x < X_ORG, tx = 0; if curr_pos_y < Y_ORG, ty = 0.
  - tx is clamped to COLS-1 and ty to ROWS-1. No unsigned underflow is allowed to propagate.
- Step, applied to the tile:
  - left: tx-1
  - right: tx+1
  - up: ty-1
  - down: ty+1
  - 4'b0000 or any non-one-hot value: no step. The output snaps to the current tile centre.
- Wrap:
  - left from column 0 goes to COLS-1; right from COLS-1 goes to 0.
  - up from row 0 goes to ROWS-1; down from ROWS-1 goes to 0.
- Pixel reconstruction:
  - new_x = X_ORG + CENTER_OFF + (tx' << TILE_SHIFT)
  - new_y = Y_ORG + CENTER_OFF + (ty' << TILE_SHIFT)
  - Computed at full width, then truncated to 11/10 bits. With the default parameters nothing overflows.
- Legality against maze walls is not checked here; the upstream valid-move logic owns it.
- Latency: the result is registered on the rising clk edge, one cycle after the inputs. Inputs are sampled every cycle, with no handshake.
- Reset and home positions:
  - While rst = 1, the output registers are asynchronously cleared to the pacman home (1367, 306).
  - While rst = 1, new_pos_x/new_pos_y are also combinationally forced to the home of which_sprite.
  - Home positions, tile then pixel:
    - pacman (64,17) -> (1367,306)
    - blinky (40,14) -> (983,258)
    - pinky (40,17) -> (983,306)
    - inky (38,17) -> (951,306)
    - clyde (42,17) -> (1015,306)
  - Deasserting rst mid-move: the first rising edge after release loads the normal computed position.
  - Asserting rst mid-move overrides the outputs immediately, with no clock required.

Optional Feature:
- Macro POS_WRAP_EN.
- Defined (project default build): edge wrap exactly as in Behaviour.
- Undefined: a step that would leave the grid is suppressed. The sprite stays at its current tile centre (column 79 + right stays at column 79; column 0 + left stays at column 0; same for rows).

Test Plan:
- Interior left: (455,146), dir 1000, rst=0 -> tile (7,7) -> next edge (439,146).
- Down: (359,434), dir 0100 -> tile (1,25) -> (359,450).
- Right-edge wrap, POS_WRAP_EN defined: (1607,443), dir 0001 -> tile (79,26) -> (343,450). With the macro undefined -> (1607,450).
- Reset: rst=1, which_sprite=0 -> outputs (1367,306) immediately, no clock edge. Then which_sprite=1 -> (983,258); which_sprite=4 -> (1015,306); which_sprite=6 -> (1367,306).
- No/invalid direction: (460,150), dir 0000 and then dir 1010 -> snap to centre (455,146).
- Top wrap and underflow: (343,34), dir 0010 -> (343,594). Input (100,10), dir 0001 -> tile (0,0) -> (359,34).
